// File: rtl/serial_frame_pkg.sv
// Shared state encoding and baud timing helper for the serial frame controller.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   // Reload that places the first sample in the middle of the start bit.
   function automatic int half_period(input int clks_per_bit);
      return (clks_per_bit / 2) - 1;
   endfunction

endpackage

// File: rtl/frame_shifter.sv
// Serial-in shift register (LSB-first words fill from the MSB) with a
// saturating bit counter whose carry marks the last data bit.
module frame_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              shift_en,
   input  logic              si,
   input  logic              cnt_ld,
   input  logic              cnt_en,
   output logic [DATA_W-1:0] data,
   output logic              carry
);
   import serial_frame_pkg::*;

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0] data_r;
   logic [CNT_W-1:0]  cnt_r;

   // Shift register and bit counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (clr) begin
            data_r <= '0;
         end else if (shift_en) begin
            data_r <= {si, data_r[DATA_W-1:1]};
         end else begin
            data_r <= data_r;
         end
         if (cnt_ld) begin
            cnt_r <= '0;
         end else if (cnt_en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign data  = data_r;
   assign carry = cnt_en & (cnt_r == CNT_LAST);

endmodule

// File: rtl/serial_frame_ctrl.sv
// Framed serial receiver: synchronizes si, times start/data/stop samples and
// delivers each good word over a valid/ready output register.
module serial_frame_ctrl #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              si,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              frm_err,
   output logic              ovr_err
);
   import serial_frame_pkg::*;

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(half_period(CLKS_PER_BIT));
   localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   state_e            state_r;
   logic [BAUD_W-1:0] baud_r;
   logic              si_meta_r, si_sync_r, si_dly_r;
   logic [DATA_W-1:0] out_data_r;
   logic              out_valid_r, busy_r, frm_err_r, ovr_err_r;
   logic              rise_s, expire_s, ld_s, shift_s, carry_s;
   logic [DATA_W-1:0] shift_data_s;

   assign rise_s   = si_sync_r & ~si_dly_r;
   assign expire_s = (baud_r == '0);

   // Shifter enables, only ever asserted while en is high.
   always_comb begin
      ld_s    = 1'b0;
      shift_s = 1'b0;
      if (en && (state_r == IDLE) && rise_s) begin
         ld_s = 1'b1;
      end else if (en && (state_r == DATA) && expire_s) begin
         shift_s = 1'b1;
      end else begin
         ld_s    = 1'b0;
         shift_s = 1'b0;
      end
   end

   frame_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (ld_s),
      .shift_en (shift_s),
      .si       (si_sync_r),
      .cnt_ld   (ld_s),
      .cnt_en   (shift_s),
      .data     (shift_data_s),
      .carry    (carry_s)
   );

   // Synchronizer, FSM, baud counter and output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         baud_r      <= '0;
         si_meta_r   <= 1'b0;
         si_sync_r   <= 1'b0;
         si_dly_r    <= 1'b0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         frm_err_r   <= 1'b0;
         ovr_err_r   <= 1'b0;
      end else if (en) begin
         si_meta_r <= si;
         si_sync_r <= si_meta_r;
         si_dly_r  <= si_sync_r;
         frm_err_r <= 1'b0;
         ovr_err_r <= 1'b0;
         if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         case (state_r)
            IDLE: begin
               if (rise_s) begin
                  baud_r  <= BAUD_HALF;
                  state_r <= START;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            START: begin
               if (!expire_s) begin
                  baud_r <= baud_r - BAUD_ONE;
               end else if (si_sync_r) begin
                  baud_r  <= BAUD_FULL;
                  state_r <= DATA;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            DATA: begin
               if (!expire_s) begin
                  baud_r <= baud_r - BAUD_ONE;
               end else begin
                  baud_r <= BAUD_FULL;
                  if (carry_s) begin
                     state_r <= STOP;
                  end else begin
                     state_r <= DATA;
                  end
               end
            end
            STOP: begin
               if (!expire_s) begin
                  baud_r <= baud_r - BAUD_ONE;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  // A late consumer loses the new word, not the held one.
                  if (si_sync_r) begin
                     frm_err_r <= 1'b1;
                  end else if (!out_valid_r || out_ready) begin
                     out_data_r  <= shift_data_s;
                     out_valid_r <= 1'b1;
                  end else begin
                     ovr_err_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end else begin
         frm_err_r <= 1'b0;
         ovr_err_r <= 1'b0;
      end
   end

   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign frm_err   = frm_err_r;
   assign ovr_err   = ovr_err_r;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl at default parameters (8 bits, 4 clk/bit).
module tb_serial_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic       si = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid, busy, frm_err, ovr_err;

   int checks = 0;
   int passes = 0;
   int frm_cnt = 0;
   int ovr_cnt = 0;
   int both_cnt = 0;
   int fc0, oc0;

   serial_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .si        (si),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .frm_err   (frm_err),
      .ovr_err   (ovr_err)
   );

   always #5 clk = ~clk;

   // Error pulse counters
   always @(negedge clk) begin
      if (frm_err) frm_cnt <= frm_cnt + 1;
      if (ovr_err) ovr_cnt <= ovr_cnt + 1;
      if (frm_err && ovr_err) both_cnt <= both_cnt + 1;
   end

   // Drives one 40-cycle frame starting at the current negedge; optionally
   // drops en for 5 cycles at cycle hold_at while holding si.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int hold_at);
      logic [9:0] bits;
      bits = {stop_bit, d, 1'b1};
      for (int i = 0; i < 40; i++) begin
         si = bits[i/4];
         if (i == hold_at) begin
            en = 1'b0;
            repeat (5) @(negedge clk);
            en = 1'b1;
         end
         @(negedge clk);
      end
      si = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL consume_valid: got %b want 0", out_valid); else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passes++;
      checks++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
      checks++; if (frm_err !== 1'b0) $display("FAIL reset_frm: got %b want 0", frm_err); else passes++;
      checks++; if (ovr_err !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr_err); else passes++;
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_frame();
      send_frame(8'hA5, 1'b0, -1);
      checks++; if (out_valid !== 1'b0) $display("FAIL good_early_valid: got %b want 0", out_valid); else passes++;
      checks++; if (busy !== 1'b1) $display("FAIL good_busy_stop: got %b want 1", busy); else passes++;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL good_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_data !== 8'hA5) $display("FAIL good_data: got %h want a5", out_data); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL good_busy_idle: got %b want 0", busy); else passes++;
      checks++; if (frm_err !== 1'b0) $display("FAIL good_frm: got %b want 0", frm_err); else passes++;
      repeat (5) @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL good_hold_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_data !== 8'hA5) $display("FAIL good_hold_data: got %h want a5", out_data); else passes++;
      consume();
   endtask

   task automatic test_glitch();
      fc0 = frm_cnt;
      oc0 = ovr_cnt;
      si = 1'b1;
      @(negedge clk);
      si = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1) $display("FAIL glitch_busy_start: got %b want 1", busy); else passes++;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_idle: got %b want 0", busy); else passes++;
      repeat (40) @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL glitch_valid: got %b want 0", out_valid); else passes++;
      checks++; if (frm_cnt !== fc0) $display("FAIL glitch_frm_cnt: got %0d want %0d", frm_cnt, fc0); else passes++;
      checks++; if (ovr_cnt !== oc0) $display("FAIL glitch_ovr_cnt: got %0d want %0d", ovr_cnt, oc0); else passes++;
   endtask

   task automatic test_framing();
      fc0 = frm_cnt;
      send_frame(8'h3C, 1'b1, -1);
      @(negedge clk);
      checks++; if (frm_err !== 1'b1) $display("FAIL frm_pulse: got %b want 1", frm_err); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL frm_valid: got %b want 0", out_valid); else passes++;
      checks++; if (ovr_err !== 1'b0) $display("FAIL frm_ovr: got %b want 0", ovr_err); else passes++;
      @(negedge clk);
      checks++; if (frm_err !== 1'b0) $display("FAIL frm_pulse_end: got %b want 0", frm_err); else passes++;
      repeat (3) @(negedge clk);
      send_frame(8'h96, 1'b0, -1);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL frm_next_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_data !== 8'h96) $display("FAIL frm_next_data: got %h want 96", out_data); else passes++;
      checks++; if (frm_cnt !== fc0 + 1) $display("FAIL frm_cnt: got %0d want %0d", frm_cnt, fc0 + 1); else passes++;
      consume();
   endtask

   task automatic test_overrun();
      oc0 = ovr_cnt;
      send_frame(8'h11, 1'b0, -1);
      send_frame(8'h22, 1'b0, -1);
      @(negedge clk);
      checks++; if (ovr_err !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", ovr_err); else passes++;
      checks++; if (out_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_data !== 8'h11) $display("FAIL ovr_data: got %h want 11", out_data); else passes++;
      @(negedge clk);
      checks++; if (ovr_err !== 1'b0) $display("FAIL ovr_pulse_end: got %b want 0", ovr_err); else passes++;
      checks++; if (ovr_cnt !== oc0 + 1) $display("FAIL ovr_cnt: got %0d want %0d", ovr_cnt, oc0 + 1); else passes++;
      consume();
   endtask

   task automatic test_back_to_back_accept();
      oc0 = ovr_cnt;
      send_frame(8'h11, 1'b0, -1);
      send_frame(8'h22, 1'b0, -1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (ovr_err !== 1'b0) $display("FAIL acc_ovr: got %b want 0", ovr_err); else passes++;
      checks++; if (out_valid !== 1'b1) $display("FAIL acc_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_data !== 8'h22) $display("FAIL acc_data: got %h want 22", out_data); else passes++;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL acc_valid_hold: got %b want 1", out_valid); else passes++;
      checks++; if (ovr_cnt !== oc0) $display("FAIL acc_ovr_cnt: got %0d want %0d", ovr_cnt, oc0); else passes++;
      consume();
   endtask

   task automatic test_enable_hold();
      send_frame(8'h5A, 1'b0, 20);
      checks++; if (out_valid !== 1'b0) $display("FAIL hold_early_valid: got %b want 0", out_valid); else passes++;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL hold_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_data !== 8'h5A) $display("FAIL hold_data: got %h want 5a", out_data); else passes++;
      consume();
   endtask

   task automatic test_reset_mid();
      send_frame(8'h0F, 1'b0, -1);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", out_valid); else passes++;
      si = 1'b1;
      repeat (12) @(negedge clk);
      checks++; if (busy !== 1'b1) $display("FAIL rmid_busy_data: got %b want 1", busy); else passes++;
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid); else passes++;
      checks++; if (out_data !== 8'h00) $display("FAIL rmid_data: got %h want 00", out_data); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passes++;
      @(negedge clk);
      si = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(8'hC3, 1'b0, -1);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL rmid_next_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_data !== 8'hC3) $display("FAIL rmid_next_data: got %h want c3", out_data); else passes++;
      consume();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back_accept();
      test_enable_hold();
      test_reset_mid();
      repeat (2) @(negedge clk);
      checks++; if (both_cnt !== 0) $display("FAIL err_exclusive: got %0d want 0", both_cnt); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
